// File: rtl/mini_cpu_seq_if.sv
// mini_cpu_seq_if: req/ack/busy handshake between the
// instruction sequencer and the LCD writer.
interface mini_cpu_seq_if;
    logic lcd_req;
    logic lcd_cmd;
    logic lcd_ack;
    logic lcd_busy;

    modport master (
        output lcd_req,
        output lcd_cmd,
        input  lcd_ack,
        input  lcd_busy
    );

    modport slave (
        input  lcd_req,
        input  lcd_cmd,
        output lcd_ack,
        output lcd_busy
    );
endinterface

// File: rtl/mini_cpu_seq.sv
// mini_cpu_seq: debounced send button, instruction latch/decode
// and read/exec/write sequencing for the mini CPU datapath and LCD.
module mini_cpu_seq #(
    parameter bit FAST_SIM        = 1'b0,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        power_on,
    input  logic        btn_enviar,
    input  logic [17:0] instrucao,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    output logic [3:0]  rf_waddr,
    output logic        rf_we,
    output logic        rf_clr,
    output logic [2:0]  alu_op,
    output logic        use_imm,
    output logic [15:0] imm_ext,
    output logic        busy,
    mini_cpu_seq_if.master lcd
);
    localparam int TH = FAST_SIM ? 4 : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(TH + 1);

    localparam logic [2:0] OP_CLEAR = 3'b110;
    localparam logic [2:0] OP_DISP  = 3'b111;

    typedef enum logic [3:0] {
        S_OFF, S_INIT, S_INIT_WAIT, S_IDLE, S_DECODE,
        S_READ, S_EXEC, S_WRITE, S_LCD_REQ, S_LCD_WAIT
    } state_t;

    state_t          r_state;
    logic            r_sync1, r_sync2;
    logic [CW-1:0]   r_cnt;
    logic            r_fired;
    logic [3:0]      r_raddr_a, r_raddr_b, r_waddr;
    logic [2:0]      r_op;
    logic            r_use_imm;
    logic [15:0]     r_imm;
    logic            r_rf_we, r_rf_clr;
    logic            r_lcd_req, r_lcd_cmd;
    logic            r_busy;

    logic            w_accept;
    logic            w_take;
    logic [2:0]      w_op;
    logic [15:0]     w_mag;
    logic [15:0]     w_imm;

    assign w_accept = (r_cnt == CW'(TH)) && !r_fired;
    assign w_take   = (r_state == S_IDLE) && w_accept;
    assign w_op     = instrucao[17:15];
    assign w_mag    = {10'd0, instrucao[5:0]};
    // negating a zero magnitude yields zero, so -0 needs no special case
    assign w_imm    = instrucao[6] ? (~w_mag + 16'd1) : w_mag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_fired <= 1'b0;
        end else begin
            r_sync1 <= btn_enviar;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_cnt   <= '0;
                r_fired <= 1'b0;
            end else begin
                if (r_cnt != CW'(TH)) r_cnt <= r_cnt + 1'b1;
                if (w_accept) r_fired <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_raddr_a <= '0;
            r_raddr_b <= '0;
            r_waddr   <= '0;
            r_op      <= '0;
            r_use_imm <= 1'b0;
            r_imm     <= '0;
        end else if (!power_on) begin
            r_raddr_a <= '0;
            r_raddr_b <= '0;
            r_waddr   <= '0;
            r_op      <= '0;
            r_use_imm <= 1'b0;
            r_imm     <= '0;
        end else if (w_take) begin
            r_op      <= w_op;
            r_waddr   <= instrucao[14:11];
            r_raddr_a <= instrucao[10:7];
            r_raddr_b <= instrucao[3:0];
            r_use_imm <= (w_op == 3'b000) || (w_op == 3'b010)
                      || (w_op == 3'b100);
            r_imm     <= w_imm;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_OFF;
            r_rf_we   <= 1'b0;
            r_rf_clr  <= 1'b0;
            r_lcd_req <= 1'b0;
            r_lcd_cmd <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_rf_we  <= 1'b0;
            r_rf_clr <= 1'b0;
            if (!power_on) begin
                r_state   <= S_OFF;
                r_lcd_req <= 1'b0;
                r_lcd_cmd <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_OFF: begin
                        r_state   <= S_INIT;
                        r_lcd_req <= 1'b1;
                        r_lcd_cmd <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                    S_INIT: if (lcd.lcd_ack) begin
                        r_state   <= S_INIT_WAIT;
                        r_lcd_req <= 1'b0;
                        r_lcd_cmd <= 1'b0;
                    end
                    S_INIT_WAIT: if (!lcd.lcd_busy) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    S_IDLE: if (w_accept) begin
                        r_state  <= S_DECODE;
                        r_busy   <= 1'b1;
                        r_rf_clr <= (w_op == OP_CLEAR);
                    end
                    S_DECODE: begin
                        if (r_op == OP_CLEAR) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                    S_READ: begin
                        if (r_op == OP_DISP) begin
                            r_state   <= S_LCD_REQ;
                            r_lcd_req <= 1'b1;
                            r_lcd_cmd <= 1'b0;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        r_state <= S_WRITE;
                        r_rf_we <= 1'b1;
                    end
                    S_WRITE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    S_LCD_REQ: if (lcd.lcd_ack) begin
                        r_state   <= S_LCD_WAIT;
                        r_lcd_req <= 1'b0;
                    end
                    S_LCD_WAIT: if (!lcd.lcd_busy) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state   <= S_OFF;
                        r_lcd_req <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rf_raddr_a  = r_raddr_a;
    assign rf_raddr_b  = r_raddr_b;
    assign rf_waddr    = r_waddr;
    assign rf_we       = r_rf_we;
    assign rf_clr      = r_rf_clr;
    assign alu_op      = r_op;
    assign use_imm     = r_use_imm;
    assign imm_ext     = r_imm;
    assign busy        = r_busy;
    assign lcd.lcd_req = r_lcd_req;
    assign lcd.lcd_cmd = r_lcd_cmd;
endmodule

// File: doc/mini_cpu_seq.md
# mini_cpu_seq

Instruction sequencer for the mini CPU. Debounces the send button, latches the 18-bit instruction and decodes it. It then steps the register file / ALU datapath through read, execute and write-back, one instruction at a time. DISPLAY and power-up LCD clear are handed to the LCD writer over a req/ack/busy handshake. The block sits between the board inputs and the datapath plus LCD driver inside `module_mini_cpu`.

## Interface
- `FAST_SIM`, 1'b0, when 1 the debounce threshold becomes 4 cycles (simulation only).
- `DEBOUNCE_CYCLES`, 1_000_000, number of stable-high cycles required to accept a press (20 ms at 50 MHz).
- `clk`  in  1  system clock, 50 MHz; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `power_on`  in  1  level; low forces the OFF state.
- `btn_enviar`  in  1  raw send button, active high, asynchronous to `clk`.
- `instrucao`  in  18  instruction switches; sampled only at accept.
- `rf_raddr_a`, `rf_raddr_b`  out  4  register-file read addresses (src1, src2).
- `rf_waddr`  out  4  write address (dest).
- `rf_we`  out  1  one-cycle write strobe.
- `rf_clr`  out  1  one-cycle clear-all strobe.
- `alu_op`  out  3  latched opcode.
- `use_imm`  out  1  ALU operand B = `imm_ext`.
- `imm_ext`  out  16  sign-magnitude immediate, converted to two's complement: {sign}? −imm : +imm.
- `lcd_req`  out  1  display request, held until `lcd_ack`.
- `lcd_cmd`  out  1  0 = show `rf_raddr_a` register, 1 = clear screen.
- `lcd_ack`  in  1  one-cycle accept from the LCD writer.
- `lcd_busy`  in  1  LCD writer busy.
- `busy`  out  1  high in every state except IDLE and OFF.

## Operation
- Instruction fields: opcode[17:15], dest[14:11], src1[10:7]. Immediate forms use sign[6] and imm[5:0]; reg-reg forms use src2[3:0], with [6:4] ignored.
- Opcodes: 000 LOAD (imm), 001 ADD (reg), 010 ADDI, 011 SUB (reg), 100 SUBI, 101 MUL (reg), 110 CLEAR, 111 DISPLAY.
- `use_imm` = 1 for 000, 010 and 100.
- Button path: 2-FF synchronizer, then a counter of consecutive high samples.
  - An accept pulse fires when the count reaches the threshold.
  - No new pulse until the synchronized button has been seen low.
  - The counter saturates; a low sample clears it.
- States:
  - OFF → INIT when `power_on`=1.
  - INIT: `lcd_req`=1, `lcd_cmd`=1 → INIT_WAIT on `lcd_ack`.
  - INIT_WAIT → IDLE when `lcd_busy`=0.
  - IDLE → DECODE on accept; the instruction is latched at this edge.
  - DECODE → READ; CLEAR goes to IDLE instead, asserting `rf_clr` during DECODE.
  - READ → EXEC, except DISPLAY, which goes to LCD_REQ.
  - EXEC → WRITE.
  - WRITE (`rf_we`=1) → IDLE.
  - LCD_REQ (`lcd_req`=1, `lcd_cmd`=0) → LCD_WAIT on `lcd_ack`.
  - LCD_WAIT → IDLE when `lcd_busy`=0.
- Accept pulses arriving while not in IDLE are dropped; they are not queued.
- `power_on`=0 in any state → OFF on the next edge. This drops `lcd_req` and aborts the instruction; no `rf_we` is issued.
- Address and opcode outputs hold the latched instruction until the next accept.

## Timing
- Reset values: all outputs 0, state OFF, debounce counter 0, latched instruction 0.
- Accept pulse at cycle S is the first cycle the count equals the threshold. Raw high → S takes threshold + 2 cycles (synchronizer).
- ALU instructions:
  - S+1 DECODE: fields valid on the outputs.
  - S+2 READ, S+3 EXEC.
  - S+4 WRITE: `rf_we`=1 for exactly one cycle.
  - S+5 IDLE.
- CLEAR: `rf_clr`=1 at S+1, IDLE at S+2.
- DISPLAY: `lcd_req` rises at S+3. It falls the cycle after `lcd_ack` is seen. If `lcd_ack` and `lcd_busy`=0 arrive together, the block goes to LCD_WAIT and then to IDLE on the next edge.
- `busy` is a registered state decode: high from S+1 until the cycle before IDLE.
- `imm_ext`: −0 is encoded as 0. The range is −63..+63.

## Test plan
- Reset, then `power_on`=1, then `lcd_ack` after 3 cycles with `lcd_busy` high for 5 cycles → one `lcd_req` with `lcd_cmd`=1; IDLE after `lcd_busy` drops; `busy`=0.
- LOAD R1 +5 ({000,1,0,0,000101}), FAST_SIM → `rf_waddr`=1, `use_imm`=1, `imm_ext`=16'd5, `rf_we` exactly one pulse 4 cycles after accept.
- ADD R2=R1+R1 ({001,2,1,000,1}) → `rf_raddr_a`=1, `rf_raddr_b`=1, `alu_op`=001, `use_imm`=0, one `rf_we` with `rf_waddr`=2. SUBI with sign=1, imm=3 → `imm_ext`=16'hFFFD.
- DISPLAY R2 ({111,2,...}), `lcd_ack` delayed 10 cycles → `lcd_req` held 10 cycles, `lcd_cmd`=0, `rf_raddr_a`=2, no `rf_we`.
- Button bounce (high 2 / low 1 / high 6 cycles) → a single accept. A second press during EXEC → ignored, exactly one `rf_we`.
- `power_on`=0 in EXEC, and separately during LCD_WAIT → OFF next edge, all outputs 0, no `rf_we`. Async `reset_n` low mid-WRITE → outputs 0 immediately.
